// File: rtl/sram_arbiter.sv
// Two-requester round-robin front end for a single sram_driver.
// Latches the winner, pulses drv_start once, and aborts via watchdog if ready never returns.
module sram_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_re,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_re,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              err,
  output logic              busy,
  output logic              drv_start,
  output logic              drv_re,
  output logic [ADDR_W-1:0] drv_address,
  output logic [DATA_W-1:0] drv_data_in,
  input  logic              drv_ready,
  input  logic [DATA_W-1:0] drv_data_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t                 state_q;
  logic                   last_q, gnt_q;
  logic [7:0]             cnt_q;
  logic [1:0]             ack_q, done_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   err_q, busy_q, start_q, re_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;

  logic [1:0]        req;
  logic              gnt_d, sel_re;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {r1_req, r0_req};
  // On a tie the requester that lost last time wins; otherwise the lone requester.
  assign gnt_d     = (req == 2'b11) ? ~last_q : req[1];
  assign sel_re    = gnt_d ? r1_re      : r0_re;
  assign sel_addr  = gnt_d ? r1_address : r0_address;
  assign sel_wdata = gnt_d ? r1_wdata   : r0_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (drv_ready && (|req)) begin
            gnt_q        <= gnt_d;
            last_q       <= gnt_d;
            re_q         <= sel_re;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            start_q      <= 1'b1;
            ack_q[gnt_d] <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // Driver samples start on this edge; its ready still reflects the previous job.
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          if (drv_ready) begin
            done_q[gnt_q] <= 1'b1;
            if (re_q) rdata_q[gnt_q] <= drv_data_out;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == TO_CNT) begin
            done_q[gnt_q] <= 1'b1;
            err_q         <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_ack      = ack_q[0];
  assign r1_ack      = ack_q[1];
  assign r0_done     = done_q[0];
  assign r1_done     = done_q[1];
  assign r0_rdata    = rdata_q[0];
  assign r1_rdata    = rdata_q[1];
  assign err         = err_q;
  assign busy        = busy_q;
  assign drv_start   = start_q;
  assign drv_re      = re_q;
  assign drv_address = addr_q;
  assign drv_data_in = wdata_q;
endmodule
